// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: request/response handshake between a client and ram_ctrl
interface ram_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int AW = 4
);
  logic req_valid, req_ready, req_write, rsp_valid;
  logic [AW-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata, rsp_data;
  modport master(output req_valid, req_write, req_addr, req_wdata, input req_ready, rsp_valid, rsp_data);
  modport slave(input req_valid, req_write, req_addr, req_wdata, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: valid/ready front end for a single-port sync RAM with full-memory clear
module ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int N_WORDS = 16,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int AW = $clog2(N_WORDS)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_start,
  ram_ctrl_if.slave bus,
  output logic busy,
  output logic clear_done,
  output logic ram_we,
  output logic ram_re,
  output logic [AW-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  typedef enum logic {CLEAR, IDLE} state_t;
  localparam logic [AW-1:0] LAST = AW'(N_WORDS - 1);
  state_t state, state_n;
  logic [AW-1:0] clr_cnt;
  logic [1:0] rd_pipe;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic accept, clearing;
  always_comb begin
    clearing = state == CLEAR;
    bus.req_ready = !clearing && !clear_start;
    accept = bus.req_ready && bus.req_valid;
    busy = clearing;
    ram_we = clearing || (accept && bus.req_write);
    ram_re = accept && !bus.req_write;
    ram_address = clearing ? clr_cnt : accept ? bus.req_addr : '0;
    ram_data_in = clearing ? CLEAR_VALUE : ram_we ? bus.req_wdata : '0;
    state_n = clearing ? (clr_cnt == LAST ? IDLE : CLEAR) : (clear_start ? CLEAR : IDLE);
  end
  // rd_pipe[0] marks the cycle ram_data_out is driven; rd_pipe[1] is the response pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      clr_cnt <= '0;
      rd_pipe <= '0;
      rsp_data <= '0;
      clear_done <= 1'b0;
    end else begin
      state <= state_n;
      clr_cnt <= (clearing && clr_cnt != LAST) ? clr_cnt + 1'b1 : '0;
      rd_pipe <= {rd_pipe[0], ram_re};
      if (rd_pipe[0]) rsp_data <= ram_data_out;
      clear_done <= clearing && clr_cnt == LAST;
    end
  end
  assign bus.rsp_valid = rd_pipe[1];
  assign bus.rsp_data = rsp_data;
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed scenarios plus a randomized run against a memory-image reference model
module tb_ram_ctrl;
  localparam int DW = 8, N = 16, AW = 4;
  localparam logic [DW-1:0] CV = 8'hA5;
  logic clk = 0, rst = 1, clear_start = 0;
  logic busy, clear_done, ram_we, ram_re;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in, ram_data_out;
  logic [DW-1:0] ram_mem [N];
  logic [DW-1:0] mdl [N];
  int vecs = 0, errs = 0;

  ram_ctrl_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();
  ram_ctrl #(.DATA_WIDTH(DW), .N_WORDS(N), .CLEAR_VALUE(CV)) dut (
    .clk(clk), .rst(rst), .clear_start(clear_start), .bus(bus),
    .busy(busy), .clear_done(clear_done), .ram_we(ram_we), .ram_re(ram_re),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // attached RAM: data_out carries garbage except in the cycle after a read
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_address] <= ram_data_in;
    ram_data_out <= ram_re ? ram_mem[ram_address] : DW'($urandom);
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr = a;
    bus.req_wdata = d;
  endtask

  task automatic test_reset;
    logic [31:0] g, e;
    rst = 1;
    clear_start = 0;
    set_req(0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    vecs++;
    g = {bus.rsp_valid, bus.rsp_data, clear_done, busy, bus.req_ready, ram_re};
    e = {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    if (g !== e) begin errs++; $display("FAIL reset_values: got %h exp %h", g, e); end
    nxt;
    rst = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      vecs++;
      g = {busy, bus.req_ready, ram_we, ram_re, ram_address, ram_data_in, clear_done, bus.rsp_valid};
      e = {1'b1, 1'b0, 1'b1, 1'b0, AW'(i), CV, 1'b0, 1'b0};
      if (g !== e) begin errs++; $display("FAIL reset_clear[%0d]: got %h exp %h", i, g, e); end
      nxt;
    end
    foreach (mdl[j]) mdl[j] = CV;
    set_req(1, 0, 7, 0);
    @(negedge clk);
    vecs++;
    g = {clear_done, busy, bus.req_ready, ram_we, ram_re, ram_address};
    e = {3'b101, 2'b01, 4'd7};
    if (g !== e) begin errs++; $display("FAIL clear_done_ready: got %h exp %h", g, e); end
    nxt;
    set_req(0, 0, 0, 0);
    @(negedge clk);
    vecs++;
    g = {clear_done, bus.rsp_valid};
    if (g !== 0) begin errs++; $display("FAIL done_pulse_once: got %h exp 0", g); end
    nxt;
    @(negedge clk);
    vecs++;
    g = {bus.rsp_valid, bus.rsp_data};
    e = {1'b1, mdl[7]};
    if (g !== e) begin errs++; $display("FAIL read_after_clear: got %h exp %h", g, e); end
    nxt;
  endtask

  task automatic test_write_read;
    logic [31:0] g, e;
    set_req(1, 1, 4, 8'h3C);
    @(negedge clk);
    vecs++;
    g = {ram_we, ram_re, ram_address, ram_data_in};
    e = {2'b10, 4'd4, 8'h3C};
    if (g !== e) begin errs++; $display("FAIL wr_pins: got %h exp %h", g, e); end
    mdl[4] = 8'h3C;
    nxt;
    set_req(1, 0, 4, 0);
    @(negedge clk);
    vecs++;
    g = {ram_we, ram_re, ram_address};
    e = {2'b01, 4'd4};
    if (g !== e) begin errs++; $display("FAIL rd_pins: got %h exp %h", g, e); end
    nxt;
    set_req(0, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL rd_early: got %b exp 0", bus.rsp_valid); end
    nxt;
    @(negedge clk);
    vecs++;
    g = {bus.rsp_valid, bus.rsp_data};
    e = {1'b1, mdl[4]};
    if (g !== e) begin errs++; $display("FAIL wr_then_rd: got %h exp %h", g, e); end
    nxt;
  endtask

  task automatic test_stream;
    logic [31:0] g, e;
    for (int i = 0; i < 4; i++) begin
      set_req(1, 1, AW'(i), DW'(10 + i));
      mdl[i] = DW'(10 + i);
      nxt;
    end
    for (int c = 0; c < 7; c++) begin
      if (c < 4) set_req(1, 0, AW'(c), 0);
      else set_req(0, 0, 0, 0);
      @(negedge clk);
      vecs++;
      g = {ram_we, bus.rsp_valid, bus.rsp_data};
      if (c >= 2 && c < 6) begin
        e = {1'b0, 1'b1, mdl[c-2]};
        if (g !== e) begin errs++; $display("FAIL stream[%0d]: got %h exp %h", c, g, e); end
      end else if (g[9:8] !== 2'b00) begin
        errs++; $display("FAIL stream_idle[%0d]: got %h exp 0", c, g[9:8]);
      end
      nxt;
    end
  endtask

  task automatic test_clear_priority;
    logic [31:0] g, e;
    clear_start = 1;
    set_req(1, 1, 9, 8'h5A);
    @(negedge clk);
    vecs++;
    g = {bus.req_ready, ram_we, ram_re};
    if (g !== 0) begin errs++; $display("FAIL prio_reject: got %h exp 0", g); end
    nxt;
    clear_start = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      vecs++;
      g = {busy, bus.req_ready, ram_we, ram_re, ram_address, ram_data_in};
      e = {1'b1, 1'b0, 1'b1, 1'b0, AW'(i), CV};
      if (g !== e) begin errs++; $display("FAIL prio_clear[%0d]: got %h exp %h", i, g, e); end
      nxt;
    end
    foreach (mdl[j]) mdl[j] = CV;
    @(negedge clk);
    vecs++;
    g = {clear_done, bus.req_ready, ram_we, ram_address, ram_data_in};
    e = {3'b111, 4'd9, 8'h5A};
    if (g !== e) begin errs++; $display("FAIL prio_represent: got %h exp %h", g, e); end
    mdl[9] = 8'h5A;
    nxt;
    set_req(1, 0, 9, 0);
    nxt;
    set_req(0, 0, 0, 0);
    nxt;
    @(negedge clk);
    vecs++;
    g = {bus.rsp_valid, bus.rsp_data};
    e = {1'b1, mdl[9]};
    if (g !== e) begin errs++; $display("FAIL prio_landed: got %h exp %h", g, e); end
    nxt;
  endtask

  task automatic test_clear_inflight;
    logic [31:0] g, e;
    set_req(1, 1, 2, 8'h77);
    mdl[2] = 8'h77;
    nxt;
    set_req(1, 0, 2, 0);
    nxt;
    set_req(0, 0, 0, 0);
    clear_start = 1;
    @(negedge clk);
    vecs++;
    g = {bus.req_ready, ram_we, ram_re, bus.rsp_valid};
    if (g !== 0) begin errs++; $display("FAIL inflight_start: got %h exp 0", g); end
    nxt;
    clear_start = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      vecs++;
      g = {busy, ram_we, ram_address, ram_data_in, bus.rsp_valid, bus.rsp_data};
      e = {2'b11, AW'(i), CV, i == 0, i == 0 ? mdl[2] : g[7:0]};
      if (i != 0) e[7:0] = mdl[2];
      if (g !== e) begin errs++; $display("FAIL inflight_clear[%0d]: got %h exp %h", i, g, e); end
      nxt;
    end
    foreach (mdl[j]) mdl[j] = CV;
    set_req(1, 0, 2, 0);
    nxt;
    set_req(0, 0, 0, 0);
    nxt;
    @(negedge clk);
    vecs++;
    g = {bus.rsp_valid, bus.rsp_data};
    e = {1'b1, mdl[2]};
    if (g !== e) begin errs++; $display("FAIL inflight_after: got %h exp %h", g, e); end
    nxt;
  endtask

  task automatic test_reset_mid;
    logic [31:0] g, e;
    clear_start = 1;
    nxt;
    clear_start = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) rst = 1;
      @(negedge clk);
      vecs++;
      g = {ram_we, ram_address};
      e = {1'b1, AW'(i)};
      if (g !== e) begin errs++; $display("FAIL mid_pre[%0d]: got %h exp %h", i, g, e); end
      nxt;
    end
    rst = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      vecs++;
      g = {busy, ram_we, ram_address, ram_data_in, clear_done};
      e = {2'b11, AW'(i), CV, 1'b0};
      if (g !== e) begin errs++; $display("FAIL mid_restart[%0d]: got %h exp %h", i, g, e); end
      nxt;
    end
    foreach (mdl[j]) mdl[j] = CV;
    set_req(1, 0, 3, 0);
    nxt;
    set_req(0, 0, 0, 0);
    rst = 1;
    nxt;
    rst = 0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      vecs++;
      g = {bus.rsp_valid, bus.rsp_data, busy, clear_done};
      e = {1'b0, 8'h00, i < N, i == N};
      if (g !== e) begin errs++; $display("FAIL drop_read[%0d]: got %h exp %h", i, g, e); end
      nxt;
    end
  endtask

  task automatic test_random;
    logic [DW-1:0] q_data[$];
    int q_due[$];
    int left = 0;
    logic done_exp = 0;
    logic [31:0] g, e;
    for (int n = 0; n < 400; n++) begin
      logic cs, v, w, rdy;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      cs = n < 370 && $urandom_range(0, 24) == 0;
      v = n < 370 && $urandom_range(0, 9) < 7;
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom);
      d = DW'($urandom);
      clear_start = cs;
      set_req(v, w, a, d);
      rdy = left == 0 && !cs;
      @(negedge clk);
      vecs++;
      g = {busy, bus.req_ready, clear_done, ram_we & ram_re};
      e = {left != 0, rdy, done_exp, 1'b0};
      if (g !== e) begin errs++; $display("FAIL rnd_ctrl[%0d]: got %h exp %h", n, g, e); end
      vecs++;
      g = {ram_we, ram_re, ram_address, ram_data_in};
      if (left != 0) begin
        e = {2'b10, AW'(N - left), CV};
        mdl[N-left] = CV;
      end else if (v && rdy) begin
        e = w ? {2'b10, a, d} : {2'b01, a, 8'h00};
        if (w) mdl[a] = d;
        else begin
          q_data.push_back(mdl[a]);
          q_due.push_back(n + 2);
        end
      end else e = {2'b00, g[11:0]};
      if (left == 0 && !(v && rdy)) e[11:0] = g[11:0];
      if (g[13:12] !== e[13:12] || (e[13:12] != 2'b00 && g !== e)) begin
        errs++; $display("FAIL rnd_pins[%0d]: got %h exp %h", n, g, e);
      end
      vecs++;
      if (q_due.size() != 0 && q_due[0] == n) begin
        g = {bus.rsp_valid, bus.rsp_data};
        e = {1'b1, q_data[0]};
        void'(q_data.pop_front());
        void'(q_due.pop_front());
        if (g !== e) begin errs++; $display("FAIL rnd_rsp[%0d]: got %h exp %h", n, g, e); end
      end else if (bus.rsp_valid !== 1'b0) begin
        errs++; $display("FAIL rnd_spurious[%0d]: got %b exp 0", n, bus.rsp_valid);
      end
      done_exp = left == 1;
      if (left != 0) left--;
      else if (cs) left = N;
      nxt;
    end
    vecs++;
    if (q_due.size() != 0) begin errs++; $display("FAIL rnd_drain: got %0d pending exp 0", q_due.size()); end
    clear_start = 0;
    set_req(0, 0, 0, 0);
  endtask

  initial begin
    set_req(0, 0, 0, 0);
    test_reset;
    test_write_read;
    test_stream;
    test_clear_priority;
    test_clear_inflight;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Initiator-side controller for the team's single-port synchronous `ram` block, parameterized by data width and depth. It accepts read/write requests on a valid/ready front end and drives the RAM's `we`/`re`/`address`/`data_in` pins. It returns read data on a registered response port and clears the whole memory to a constant after reset or on command. It sits between a datapath or bus client and one `ram` instance; the RAM ports connect pin-for-pin.

## Interface
- `DATA_WIDTH`, 8, word width; must match the attached RAM
- `N_WORDS`, 16, RAM depth; address width `AW = $clog2(N_WORDS)`
- `CLEAR_VALUE`, 0, word written to every address during a clear sequence
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  reset; synchronous and active-high
- `clear_start`  in  1  pulse in IDLE to start a full-memory clear
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller accepts the request this cycle
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  AW  request address
- `req_wdata`  in  DATA_WIDTH  write data
- `rsp_valid`  out  1  one-cycle pulse; `rsp_data` holds read data
- `rsp_data`  out  DATA_WIDTH  read data, held until the next response
- `busy`  out  1  high while clearing
- `clear_done`  out  1  one-cycle pulse when a clear completes
- `ram_we`, `ram_re`  out  1 each  to RAM `we`/`re`
- `ram_address`  out  AW  to RAM `address`
- `ram_data_in`  out  DATA_WIDTH  to RAM `data_in`
- `ram_data_out`  in  DATA_WIDTH  from RAM `data_out`; high-Z except in the cycle after a read

## Operation
- States: CLEAR and IDLE. Reset enters CLEAR with `clr_cnt = 0`.
- **CLEAR**
  - Drive `ram_we=1`, `ram_re=0`, `ram_address=clr_cnt`, `ram_data_in=CLEAR_VALUE`.
  - `clr_cnt` increments every cycle.
  - On the cycle with `clr_cnt == N_WORDS-1`, go to IDLE and register `clear_done=1` for one cycle.
  - `req_ready=0` and `busy=1` throughout.
- **IDLE**
  - `req_ready = !clear_start`; accept = `req_valid & req_ready`.
  - Accept with `req_write=1`: same cycle, `ram_we=1`, `ram_address=req_addr`, `ram_data_in=req_wdata`.
  - Accept with `req_write=0`: same cycle, `ram_re=1`, `ram_address=req_addr`.
  - No accept: `ram_we=0` and `ram_re=0`; address and data outputs are don't-care, driven 0.
- **Start of a clear:** `clear_start` in IDLE has priority over a simultaneous request. The request is not accepted. Next state is CLEAR with `clr_cnt=0`. `clear_start` in CLEAR is ignored.
- **Read pipeline:** a 2-bit valid shift register tracks outstanding reads.
  - `ram_data_out` is sampled only in the cycle after `ram_re`. It is never sampled otherwise, because it is Z then.
  - A read in flight when a clear starts still completes and produces its `rsp_valid`.
- There is no response back-pressure. The consumer must take each `rsp_valid` pulse.
- `ram_we` and `ram_re` are never both 1.
- **Reset mid-operation** (including mid-clear):
  - drops all in-flight reads with no `rsp_valid`;
  - restarts CLEAR from address 0.

## Timing
- Reset values:
  - `rsp_valid=0`, `rsp_data=0`, `clear_done=0`
  - `busy=1`, `req_ready=0`, `ram_re=0`
  - `ram_we=1` on the cycle after reset, since clearing begins immediately.
- Clear duration: exactly N_WORDS cycles of `ram_we`. `clear_done` is high in the first IDLE cycle, which is also the first cycle with `req_ready=1`.
- Write: accepted in cycle k; the RAM holds the new value after the posedge that ends cycle k.
- Read latency:
  - accepted in cycle k;
  - `ram_data_out` is valid in cycle k+1;
  - `rsp_valid`/`rsp_data` are registered at the end of k+1, visible in cycle k+2.
- Throughput: one request per cycle. Back-to-back reads give back-to-back `rsp_valid` pulses in request order.
- Write in cycle k, then read of the same address in k+1: returns the new data.
- Read issued in the last IDLE cycle before a clear: its response arrives during CLEAR cycles, unaffected.

## Test plan
- **Reset clear:** N_WORDS=16, CLEAR_VALUE=8'hA5. Hold `rst` for 2 cycles, then release.
  - 16 consecutive `ram_we` cycles with addresses 0..15 and data A5.
  - `clear_done` pulses once, coinciding with `req_ready` first rising.
  - Then read address 7 → `rsp_data=A5` two cycles after accept.
- **Write-then-read:** write 8'h3C to address 4 in cycle k, read address 4 in cycle k+1 → `rsp_valid` in k+3 with `rsp_data=3C`.
- **Streaming reads:** preload addresses 0..3 with 10,11,12,13; issue 4 back-to-back reads → 4 consecutive `rsp_valid` pulses with data 10,11,12,13; `ram_we` stays 0.
- **Clear priority:** `clear_start=1` and a write request in the same IDLE cycle.
  - `req_ready=0`; the request is not accepted.
  - 16 clear cycles follow.
  - The client re-presents the request after `clear_done`; the write then lands.
- **Clear with read in flight:** read address 2 (value 8'h77), then `clear_start` the next cycle → `rsp_valid` with 77 during CLEAR; the subsequent read of address 2 returns A5.
- **Reset mid-clear and mid-read:**
  - Reset in clear cycle 9 → clearing restarts at address 0 and runs 16 cycles.
  - Reset one cycle after a read accept → no `rsp_valid` ever appears for that read.
